step_counter: RTL and testbench
===============================

// Module: step_counter
// PURPOSE
//   Parameterised, enable-gated, wrap-around counter; generic primitive for the shared library.
//   - Output starts at COUNT_FROM and moves by STEP on each enabled clock edge.
//   - After passing COUNT_TO it reloads COUNT_FROM.
//   - Used for timers, address generators and sequencing in larger datapaths.
// PARAMETERS
//   ARCHITECTURE  "BEHAVIORAL"  impl select: "BEHAVIORAL" (inferred +/-) or "STRUCTURAL" (ripple adder sub-module)
//   DATA_WIDTH    8             width of out, unsigned
//   COUNT_FROM    0             reset/reload value
//   COUNT_TO      10            terminal value, inclusive
//   STEP          1             magnitude of increment per enabled cycle, must be >= 1
// PORTS
//   clk  input  1           rising-edge clock, single clock domain
//   rst  input  1           asynchronous, active-high reset
//   en   input  1           count enable, sampled on rising clk
//   out  output DATA_WIDTH  current count, registered
// BEHAVIOUR
//   Reset
//   - rst=1 forces out=COUNT_FROM immediately, independent of clk.
//   - Reset mid-count discards progress.
//   - First enabled edge after rst deasserts produces COUNT_FROM+/-STEP.
//   Direction
//   - COUNT_TO >= COUNT_FROM: count up.
//   - Otherwise: count down.
//   - Fixed at elaboration.
//   Per rising clk with rst=0
//   - en=0: hold.
//   - en=1, up: if out+STEP > COUNT_TO then out<=COUNT_FROM, else out<=out+STEP.
//   - en=1, down: if out-STEP < COUNT_TO then out<=COUNT_FROM, else out<=out-STEP.
//   - The terminal value is reached only if it is on the step grid. No remainder carried on wrap.
//   Latency and range
//   - Latency 1 cycle from en to out change.
//   - out never leaves the closed range [COUNT_FROM, COUNT_TO].
//   Arithmetic
//   - Compare in DATA_WIDTH+1 bits so out+STEP overflow is detected, never silently wrapped mod 2^DATA_WIDTH.
//   Degenerate case
//   - COUNT_FROM == COUNT_TO: out stays constant.
//   Elaboration checks
//   - COUNT_FROM and COUNT_TO must fit in DATA_WIDTH.
//   - STEP must be >= 1.
//   - ARCHITECTURE must be a legal value.
//   - Any violation: $error at elaboration.
//   Equivalence
//   - Both ARCHITECTURE values must be cycle-identical.
// CONFIGURATION
//   STEP_COUNTER_WRAP_FLAG_EN defined
//   - Adds output port wrap (1 bit, registered).
//   - wrap=1 for exactly the cycle in which out holds the value produced by a reload to COUNT_FROM triggered by en.
//   - wrap=0 in all other cycles, during reset and after reset.
//   STEP_COUNTER_WRAP_FLAG_EN undefined
//   - Port wrap is absent; logic is otherwise identical.
// STRUCTURE
//   Shared package step_counter_pkg:
//   - architecture string constants "BEHAVIORAL" and "STRUCTURAL";
//   - function clog2;
//   - function in_range(value, width) used by the elaboration checks.
//   Sub-module step_counter_adder: DATA_WIDTH+1-bit ripple add/sub with carry-out.
//   - Instantiated only when ARCHITECTURE="STRUCTURAL".
//   - The behavioural branch uses inferred arithmetic.
// TESTING
//   1. Defaults, en=1 for 24 cycles
//      -> 0,1,...,10,0,1,...
//      -> the period is 11 cycles.
//   2. rst pulse while out=7, asynchronous to clk
//      -> out=0 before the next edge
//      -> resumes 1,2,... after release.
//   3. en low for 3 cycles at out=4 -> out holds 4, then continues with 5.
//   4. FROM=2, TO=9, STEP=3 -> 2,5,8,2,5,8.
//      FROM=9, TO=0, STEP=2 -> 9,7,5,3,1,9.
//   5. DATA_WIDTH=4, FROM=0, TO=15, STEP=4
//      -> 0,4,8,12,0, with no overflow glitch.
//      With STEP_COUNTER_WRAP_FLAG_EN defined -> wrap pulses with each 0.
//   6. Rerun cases 1-5 with ARCHITECTURE="STRUCTURAL"
//      -> traces bit-identical to BEHAVIORAL.

Source files
------------

// File: rtl/step_counter_pkg.sv
// Shared constants and elaboration helpers for step_counter.
package step_counter_pkg;

  localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
  localparam string ARCH_STRUCTURAL = "STRUCTURAL";

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // True when value is a non-negative number representable in width unsigned bits.
  function automatic bit in_range(input int value, input int width);
    if (value < 0) return 1'b0;
    if (width >= 31) return 1'b1;
    return value < (1 << width);
  endfunction

endpackage

// File: rtl/step_counter_adder.sv
// Ripple-carry add/subtract with carry-out; sub=1 computes a-b (carry=1 means no borrow).
module step_counter_adder #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] bx;

  assign bx = b ^ {WIDTH{sub}};

  always_comb begin
    logic cy;
    sum = '0;
    cy  = sub;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ bx[i] ^ cy;
      cy     = (a[i] & bx[i]) | (cy & (a[i] ^ bx[i]));
    end
    carry = cy;
  end

endmodule

// File: rtl/step_counter.sv
// Enable-gated wrap-around counter, direction fixed at elaboration.
// Optional registered wrap pulse output when STEP_COUNTER_WRAP_FLAG_EN is defined.
module step_counter
  import step_counter_pkg::*;
#(
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    DATA_WIDTH   = 8,
  parameter int    COUNT_FROM   = 0,
  parameter int    COUNT_TO     = 10,
  parameter int    STEP         = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
`ifdef STEP_COUNTER_WRAP_FLAG_EN
  output logic                  wrap,
`endif
  output logic [DATA_WIDTH-1:0] out
);

  localparam int W1        = DATA_WIDTH + 1;
  localparam bit UP        = COUNT_TO >= COUNT_FROM;
  localparam int SPAN      = UP ? COUNT_TO - COUNT_FROM : COUNT_FROM - COUNT_TO;
  // A step wider than the whole range reloads every time; this also keeps
  // STEP_V from being truncated in the cases where the sum actually matters.
  localparam bit STEP_OVER = STEP > SPAN;

  localparam logic [DATA_WIDTH-1:0] FROM_V = DATA_WIDTH'(COUNT_FROM);
  localparam logic [W1-1:0]         TO_V   = W1'(COUNT_TO);
  localparam logic [W1-1:0]         STEP_V = W1'(STEP);

  if (!in_range(COUNT_FROM, DATA_WIDTH)) begin : g_chk_from
    $error("step_counter: COUNT_FROM=%0d does not fit in %0d bits", COUNT_FROM, DATA_WIDTH);
  end
  if (!in_range(COUNT_TO, DATA_WIDTH)) begin : g_chk_to
    $error("step_counter: COUNT_TO=%0d does not fit in %0d bits", COUNT_TO, DATA_WIDTH);
  end
  if (STEP < 1) begin : g_chk_step
    $error("step_counter: STEP=%0d must be >= 1", STEP);
  end
  if (ARCHITECTURE != ARCH_BEHAVIORAL && ARCHITECTURE != ARCH_STRUCTURAL) begin : g_chk_arch
    $error("step_counter: ARCHITECTURE=%s is not BEHAVIORAL or STRUCTURAL", ARCHITECTURE);
  end

  logic [W1-1:0] ext;
  logic [W1-1:0] raw;
  logic          over;
  logic          reload;

  // One guard bit above the counter so out+STEP / out-STEP never wraps silently.
  assign ext = {1'b0, out};

  if (ARCHITECTURE == ARCH_STRUCTURAL) begin : g_struct
    logic carry;

    step_counter_adder #(.WIDTH(W1)) u_add (
      .a    (ext),
      .b    (STEP_V),
      .sub  (!UP),
      .sum  (raw),
      .carry(carry)
    );

    assign over = UP ? (carry | raw[DATA_WIDTH]) : !carry;
  end else begin : g_beh
    assign raw  = UP ? ext + STEP_V : ext - STEP_V;
    // Up: guard bit means the sum left DATA_WIDTH. Down: guard bit is the borrow.
    assign over = raw[DATA_WIDTH];
  end

  assign reload = STEP_OVER || over || (UP ? (raw > TO_V) : (raw < TO_V));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= FROM_V;
    end else if (en) begin
      out <= reload ? FROM_V : raw[DATA_WIDTH-1:0];
    end
  end

`ifdef STEP_COUNTER_WRAP_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= en && reload;
    end
  end
`endif

endmodule

// File: tb/tb_step_counter.sv
// Scoreboard bench for step_counter: four parameter sets, each built BEHAVIORAL and STRUCTURAL.
module tb_step_counter;

  localparam int NC = 4;
  localparam int DWS   [NC] = '{8, 8, 8, 4};
  localparam int FROMS [NC] = '{0, 2, 9, 0};
  localparam int TOS   [NC] = '{10, 9, 0, 15};
  localparam int STEPS [NC] = '{1, 3, 2, 4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic [7:0] outs  [2*NC];
`ifdef STEP_COUNTER_WRAP_FLAG_EN
  logic       wraps [2*NC];
`endif

  always #5 clk = ~clk;

  for (genvar c = 0; c < NC; c++) begin : g_cfg
    logic [DWS[c]-1:0] ob;
    logic [DWS[c]-1:0] os;
`ifdef STEP_COUNTER_WRAP_FLAG_EN
    logic wb;
    logic ws;
    assign wraps[2*c]   = wb;
    assign wraps[2*c+1] = ws;
`endif

    step_counter #(
      .ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(DWS[c]),
      .COUNT_FROM(FROMS[c]), .COUNT_TO(TOS[c]), .STEP(STEPS[c])
    ) u_beh (
      .clk(clk), .rst(rst), .en(en),
`ifdef STEP_COUNTER_WRAP_FLAG_EN
      .wrap(wb),
`endif
      .out(ob)
    );

    step_counter #(
      .ARCHITECTURE("STRUCTURAL"), .DATA_WIDTH(DWS[c]),
      .COUNT_FROM(FROMS[c]), .COUNT_TO(TOS[c]), .STEP(STEPS[c])
    ) u_str (
      .clk(clk), .rst(rst), .en(en),
`ifdef STEP_COUNTER_WRAP_FLAG_EN
      .wrap(ws),
`endif
      .out(os)
    );

    assign outs[2*c]   = 8'(ob);
    assign outs[2*c+1] = 8'(os);
  end

  typedef struct {
    int out_v  [NC];
    bit wrap_v [NC];
  } exp_t;

  exp_t sb[$];
  int   cur [NC];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all_reset(input string tag);
    for (int c = 0; c < NC; c++) begin
      for (int a = 0; a < 2; a++) begin
        chk($sformatf("%s_c%0d_a%0d_out", tag, c, a), 32'(outs[2*c+a]), 32'(FROMS[c]));
`ifdef STEP_COUNTER_WRAP_FLAG_EN
        chk($sformatf("%s_c%0d_a%0d_wrap", tag, c, a), 32'(wraps[2*c+a]), 32'd0);
`endif
      end
    end
  endtask

  // Drive one cycle of en, push the reference result, then pop and compare after the edge.
  task automatic step(input bit e);
    exp_t x;
    en = e;
    for (int c = 0; c < NC; c++) begin
      int n;
      bit rl;
      if (TOS[c] >= FROMS[c]) begin
        n  = cur[c] + STEPS[c];
        rl = n > TOS[c];
      end else begin
        n  = cur[c] - STEPS[c];
        rl = n < TOS[c];
      end
      if (e) cur[c] = rl ? FROMS[c] : n;
      x.out_v[c]  = cur[c];
      x.wrap_v[c] = e && rl;
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    for (int c = 0; c < NC; c++) begin
      for (int a = 0; a < 2; a++) begin
        chk($sformatf("c%0d_%s_out", c, a ? "str" : "beh"), 32'(outs[2*c+a]), 32'(x.out_v[c]));
`ifdef STEP_COUNTER_WRAP_FLAG_EN
        chk($sformatf("c%0d_%s_wrap", c, a ? "str" : "beh"), 32'(wraps[2*c+a]), 32'(x.wrap_v[c]));
`endif
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NC; c++) cur[c] = FROMS[c];

    repeat (2) @(posedge clk);
    #1;
    chk_all_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // Free run: default set sweeps 0..10 twice plus two.
    repeat (24) step(1'b1);

    // Bring the default set to 7, then pulse reset between edges.
    repeat (5) step(1'b1);
    chk("pre_rst_c0", 32'(outs[0]), 32'd7);
    #2 rst = 1'b1;
    #1 chk_all_reset("async_rst");
    #1 rst = 1'b0;
    for (int c = 0; c < NC; c++) cur[c] = FROMS[c];
    repeat (4) step(1'b1);

    // Default set sits at 4: hold for three cycles, then continue.
    chk("pre_hold_c0", 32'(outs[0]), 32'd4);
    repeat (3) step(1'b0);
    chk("hold_c0", 32'(outs[0]), 32'd4);
    step(1'b1);
    chk("post_hold_c0", 32'(outs[0]), 32'd5);

    repeat (40) step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
